// File: rtl/redmule_z_store_stage.sv
// RedMulE Z store stage: queues Z rows in a small FIFO and writes each one to memory
// at base + k*stride through a req/gnt handshake, one job of rows_i rows per start.
module redmule_z_store_stage #(
  parameter int unsigned DW    = 288,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AW    = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            start_i,
  input  logic [AW-1:0]   base_addr_i,
  input  logic [AW-1:0]   stride_i,
  input  logic [15:0]     rows_i,
  input  logic [DW-1:0]   z_data_i,
  input  logic [DW/8-1:0] z_strb_i,
  input  logic            z_valid_i,
  output logic            z_ready_o,
  output logic            mem_req_o,
  input  logic            mem_gnt_i,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  output logic [DW/8-1:0] mem_be_o,
  output logic            busy_o,
  output logic            done_o
);

  localparam int unsigned SW = DW / 8;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned EW = DW + SW;
  localparam logic [PW:0]   DEPTH_C = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] stride_q, stride_d;
  logic [15:0]   rows_q, rows_d;
  logic [15:0]   acc_cnt_q, acc_cnt_d;
  logic [15:0]   iss_cnt_q, iss_cnt_d;
  logic [EW-1:0] fifo_q [DEPTH];
  logic [EW-1:0] fifo_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   cnt_q, cnt_d;

  logic full_s, empty_s, push_s, pop_s;

  assign full_s  = (cnt_q == DEPTH_C);
  assign empty_s = (cnt_q == {(PW+1){1'b0}});

  // Handshake outputs depend only on registered state, never on z_valid_i or mem_gnt_i.
  assign z_ready_o = (state_q == RUN) && !full_s && (acc_cnt_q < rows_q);
  assign mem_req_o = (state_q == RUN) && !empty_s;
  assign push_s    = z_valid_i && z_ready_o;
  assign pop_s     = mem_req_o && mem_gnt_i;

  assign {mem_wdata_o, mem_be_o} = fifo_q[rd_ptr_q];
  assign mem_addr_o = addr_q;
  assign busy_o     = (state_q == RUN);
  assign done_o     = (state_q == DONE);

  // Next-state logic for the FSM, FIFO and job counters.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    stride_d  = stride_q;
    rows_d    = rows_q;
    acc_cnt_d = acc_cnt_q;
    iss_cnt_d = iss_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      fifo_d[i] = (push_s && (wr_ptr_q == PW'(i))) ? {z_data_i, z_strb_i} : fifo_q[i];
    end

    if (clear_i) begin
      state_d   = IDLE;
      addr_d    = {AW{1'b0}};
      acc_cnt_d = 16'd0;
      iss_cnt_d = 16'd0;
      wr_ptr_d  = {PW{1'b0}};
      rd_ptr_d  = {PW{1'b0}};
      cnt_d     = {(PW+1){1'b0}};
    end else begin
      wr_ptr_d  = push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
      acc_cnt_d = push_s ? (acc_cnt_q + 16'd1) : acc_cnt_q;
      rd_ptr_d  = pop_s ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
      iss_cnt_d = pop_s ? (iss_cnt_q + 16'd1) : iss_cnt_q;
      addr_d    = pop_s ? (addr_q + stride_q) : addr_q;

      case ({push_s, pop_s})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase

      case (state_q)
        IDLE: begin
          if (start_i) begin
            addr_d    = base_addr_i;
            stride_d  = stride_i;
            rows_d    = rows_i;
            acc_cnt_d = 16'd0;
            iss_cnt_d = 16'd0;
            state_d   = (rows_i != 16'd0) ? RUN : DONE;
          end else begin
            state_d = IDLE;
          end
        end
        RUN: begin
          // Every row is pushed before its grant, so the FIFO drains on the last grant.
          if (pop_s && (iss_cnt_q == (rows_q - 16'd1))) begin
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= {AW{1'b0}};
      stride_q  <= {AW{1'b0}};
      rows_q    <= 16'd0;
      acc_cnt_q <= 16'd0;
      iss_cnt_q <= 16'd0;
      wr_ptr_q  <= {PW{1'b0}};
      rd_ptr_q  <= {PW{1'b0}};
      cnt_q     <= {(PW+1){1'b0}};
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= {EW{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      stride_q  <= stride_d;
      rows_q    <= rows_d;
      acc_cnt_q <= acc_cnt_d;
      iss_cnt_q <= iss_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

endmodule

// File: tb/tb_redmule_z_store_stage.sv
// Testbench for redmule_z_store_stage: directed job table, hand-written abort/reset
// sequences and random jobs, all checked against a queue-based store model.
module tb_redmule_z_store_stage;

  localparam int DW    = 288;
  localparam int SW    = DW / 8;
  localparam int AW    = 32;
  localparam int DEPTH = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            clear_i;
  logic            start_i;
  logic [AW-1:0]   base_addr_i;
  logic [AW-1:0]   stride_i;
  logic [15:0]     rows_i;
  logic [DW-1:0]   z_data_i;
  logic [SW-1:0]   z_strb_i;
  logic            z_valid_i;
  logic            z_ready_o;
  logic            mem_req_o;
  logic            mem_gnt_i;
  logic [AW-1:0]   mem_addr_o;
  logic [DW-1:0]   mem_wdata_o;
  logic [SW-1:0]   mem_be_o;
  logic            busy_o;
  logic            done_o;

  redmule_z_store_stage #(.DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .base_addr_i(base_addr_i), .stride_i(stride_i), .rows_i(rows_i),
    .z_data_i(z_data_i), .z_strb_i(z_strb_i), .z_valid_i(z_valid_i),
    .z_ready_o(z_ready_o), .mem_req_o(mem_req_o), .mem_gnt_i(mem_gnt_i),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] be;
  } row_t;

  // Model: a job is a list of accepted rows, stored in acceptance order at base + k*stride.
  row_t          exp_q[$];
  bit            m_active, m_done_due;
  int            m_rows, m_pushed, m_granted;
  logic [AW-1:0] m_base, m_stride;

  int            obs_grants, obs_pushes, obs_done, obs_max_occ;
  logic [AW-1:0] obs_first, obs_last;

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] stride;
    int            rows;
    int            g_stall;
    logic [AW-1:0] exp_first;
    logic [AW-1:0] exp_last;
    int            exp_grants;
    int            exp_max_occ;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] rand_row();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic logic [SW-1:0] rand_strb();
    logic [SW-1:0] s;
    s = {4'($urandom()), $urandom()};
    if ($urandom_range(7) == 0) s = {SW{1'b0}};
    return s;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_active = 1'b0; m_done_due = 1'b0;
    m_pushed = 0; m_granted = 0; m_rows = 0;
  endtask

  task automatic clear_obs();
    obs_grants = 0; obs_pushes = 0; obs_done = 0; obs_max_occ = 0;
    obs_first = '0; obs_last = '0;
  endtask

  // One clock: sample and check at the falling edge, update the model, return just after the rising edge.
  task automatic tick();
    int   occ;
    bit   idle, nd;
    logic exp_rdy, exp_req;
    row_t r;
    @(negedge clk_i);
    occ     = m_pushed - m_granted;
    idle    = !m_active && !m_done_due;
    exp_rdy = m_active && (occ < DEPTH) && (m_pushed < m_rows);
    exp_req = m_active && (occ > 0);
    if (occ > obs_max_occ) obs_max_occ = occ;
    chk("done_o", DW'(done_o), DW'(m_done_due));
    chk("busy_o", DW'(busy_o), DW'(m_active));
    chk("z_ready_o", DW'(z_ready_o), DW'(exp_rdy));
    chk("mem_req_o", DW'(mem_req_o), DW'(exp_req));
    if (exp_req && exp_q.size() > 0) begin
      chk("mem_addr_o", DW'(mem_addr_o), DW'(exp_q[0].addr));
      chk("mem_wdata_o", mem_wdata_o, exp_q[0].data);
      chk("mem_be_o", DW'(mem_be_o), DW'(exp_q[0].be));
    end
    if (done_o) obs_done++;
    nd = 1'b0;
    if (clear_i) begin
      exp_q.delete();
      m_active = 1'b0; m_pushed = 0; m_granted = 0;
    end else begin
      if (z_valid_i && z_ready_o) begin
        r.addr = m_base + 32'(m_pushed) * m_stride;
        r.data = z_data_i;
        r.be   = z_strb_i;
        exp_q.push_back(r);
        m_pushed++;
        obs_pushes++;
      end
      if (mem_req_o && mem_gnt_i) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        if (obs_grants == 0) obs_first = mem_addr_o;
        obs_last = mem_addr_o;
        obs_grants++;
        m_granted++;
        if (m_granted >= m_rows) begin
          m_active = 1'b0;
          nd = 1'b1;
        end
      end
      if (start_i && idle) begin
        m_base = base_addr_i; m_stride = stride_i; m_rows = int'(rows_i);
        m_pushed = 0; m_granted = 0;
        exp_q.delete();
        if (rows_i == 16'd0) nd = 1'b1;
        else m_active = 1'b1;
      end
    end
    m_done_due = nd;
    @(posedge clk_i);
    #1;
  endtask

  task automatic start_job(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int rows);
    int r;
    r = rows;
    start_i = 1'b1; base_addr_i = base; stride_i = stride; rows_i = r[15:0];
    z_valid_i = 1'b0; mem_gnt_i = 1'b0;
    tick();
    start_i = 1'b0;
  endtask

  task automatic run_job(input logic [AW-1:0] base, input logic [AW-1:0] stride, input int rows,
                         input int v_pct, input int g_pct, input int g_stall, input bit rand_start);
    int cyc;
    clear_obs();
    start_job(base, stride, rows);
    cyc = 0;
    while (obs_done == 0 && cyc < 3000) begin
      z_valid_i = ($urandom_range(99) < v_pct);
      z_data_i  = rand_row();
      z_strb_i  = rand_strb();
      mem_gnt_i = (cyc >= g_stall) && ($urandom_range(99) < g_pct);
      if (rand_start) begin
        start_i = ($urandom_range(9) == 0);
        base_addr_i = $urandom(); stride_i = $urandom(); rows_i = 16'($urandom_range(5));
      end
      tick();
      cyc++;
    end
    start_i = 1'b0;
    if (obs_done == 0) chk("job_timeout", DW'(obs_done), DW'(1));
    for (int i = 0; i < 2; i++) begin
      z_data_i = rand_row();
      tick();
    end
    chk("job_grants", DW'(obs_grants), DW'(rows));
    chk("job_pushes", DW'(obs_pushes), DW'(rows));
    chk("job_done_pulses", DW'(obs_done), DW'(1));
  endtask

  initial begin
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    base_addr_i = '0; stride_i = '0; rows_i = '0;
    z_data_i = '0; z_strb_i = '0; z_valid_i = 1'b0; mem_gnt_i = 1'b0;
    model_reset();
    clear_obs();

    #12;
    chk("rst_z_ready", DW'(z_ready_o), DW'(0));
    chk("rst_mem_req", DW'(mem_req_o), DW'(0));
    chk("rst_mem_addr", DW'(mem_addr_o), DW'(0));
    chk("rst_mem_wdata", mem_wdata_o, {DW{1'b0}});
    chk("rst_mem_be", DW'(mem_be_o), DW'(0));
    chk("rst_busy", DW'(busy_o), DW'(0));
    chk("rst_done", DW'(done_o), DW'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    tick();

    // base, stride, rows, grant stall, first addr, last addr, grants, peak FIFO occupancy
    vecs[0] = '{32'h0000_1000, 32'h40, 3, 0,  32'h0000_1000, 32'h0000_1080, 3, 1};
    vecs[1] = '{32'h0000_2000, 32'h20, 4, 10, 32'h0000_2000, 32'h0000_2060, 4, 2};
    vecs[2] = '{32'h0000_3000, 32'h10, 0, 0,  32'h0000_0000, 32'h0000_0000, 0, 0};
    vecs[3] = '{32'h0000_4000, 32'h08, 2, 0,  32'h0000_4000, 32'h0000_4008, 2, 1};
    vecs[4] = '{32'hFFFF_FFC0, 32'h40, 2, 0,  32'hFFFF_FFC0, 32'h0000_0000, 2, 1};
    for (int v = 0; v < 5; v++) begin
      run_job(vecs[v].base, vecs[v].stride, vecs[v].rows, 100, 100, vecs[v].g_stall, 1'b0);
      chk($sformatf("vec%0d_first_addr", v), DW'(obs_first), DW'(vecs[v].exp_first));
      chk($sformatf("vec%0d_last_addr", v), DW'(obs_last), DW'(vecs[v].exp_last));
      chk($sformatf("vec%0d_grants", v), DW'(obs_grants), DW'(vecs[v].exp_grants));
      chk($sformatf("vec%0d_max_occ", v), DW'(obs_max_occ), DW'(vecs[v].exp_max_occ));
    end

    // Abort: clear after the first grant of a 4-row job, then a fresh job must complete.
    clear_obs();
    start_job(32'h0000_5000, 32'h40, 4);
    z_valid_i = 1'b1; mem_gnt_i = 1'b1;
    for (int i = 0; i < 50 && obs_grants == 0; i++) begin
      z_data_i = rand_row(); z_strb_i = rand_strb();
      tick();
    end
    chk("abort_first_grant", DW'(obs_grants), DW'(1));
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    chk("abort_mem_req", DW'(mem_req_o), DW'(0));
    chk("abort_busy", DW'(busy_o), DW'(0));
    for (int i = 0; i < 3; i++) tick();
    chk("abort_no_done", DW'(obs_done), DW'(0));
    run_job(32'h0000_6000, 32'h40, 4, 100, 100, 0, 1'b0);
    chk("after_abort_last", DW'(obs_last), DW'(32'h0000_60C0));

    // Asynchronous reset in the middle of a job.
    clear_obs();
    start_job(32'h0000_7000, 32'h10, 6);
    z_valid_i = 1'b1; mem_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      z_data_i = rand_row(); z_strb_i = rand_strb();
      tick();
    end
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_z_ready", DW'(z_ready_o), DW'(0));
    chk("arst_mem_req", DW'(mem_req_o), DW'(0));
    chk("arst_mem_addr", DW'(mem_addr_o), DW'(0));
    chk("arst_mem_wdata", mem_wdata_o, {DW{1'b0}});
    chk("arst_mem_be", DW'(mem_be_o), DW'(0));
    chk("arst_busy", DW'(busy_o), DW'(0));
    chk("arst_done", DW'(done_o), DW'(0));
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
    clear_obs();
    for (int i = 0; i < 3; i++) tick();
    chk("arst_no_done", DW'(obs_done), DW'(0));

    // Random jobs with random valid/grant activity and ignored mid-job starts.
    for (int j = 0; j < 25; j++) begin
      run_job($urandom(), $urandom(), $urandom_range(12), $urandom_range(100, 30),
              $urandom_range(100, 30), $urandom_range(5), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
